sram_row_ctrl: RTL and testbench

- Access sequencer that sits directly upstream of the SRAM row array (ROWS instances of memcell_nbit, each N bits wide).
- Accepts single read/write requests over a valid/ready handshake and decodes the address to a one-hot row_select.
- Generates a setup / write-pulse / hold sequence on write_enable, and muxes and registers the selected row's data_out back as a read response.
- All array-facing outputs are registered, so they are glitch-free at the cell latches.

---
 rtl/sram_row_ctrl_if.sv | 32 +++
 rtl/sram_row_ctrl.sv | 145 ++++++++++++++
 tb/tb_sram_row_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_row_ctrl_if.sv
// Request/response and array-side signals of the SRAM row access sequencer.
// The master side drives requests and the row array; the controller is the slave.
interface sram_row_ctrl_if #(
  parameter int N      = 8,
  parameter int ROWS   = 8,
  parameter int ADDR_W = 3
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // rsp_valid is a one-cycle pulse with no backpressure.
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [N-1:0]      req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [N-1:0]      rsp_rdata;
  logic [ROWS-1:0]   row_select;
  logic              write_enable;
  logic [N-1:0]      mem_data_in;
  logic [ROWS*N-1:0] mem_data_out;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, row_select, write_enable, mem_data_in
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, row_select, write_enable, mem_data_in
  );
endinterface

// File: rtl/sram_row_ctrl.sv
// Single-request access sequencer in front of an SRAM row array: setup / pulse / hold
// write timing and a registered read response, with every array-facing output registered.
module sram_row_ctrl #(
  parameter int N         = 8,
  parameter int ROWS      = 8,
  parameter int ADDR_W    = 3,
  parameter int WE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  sram_row_ctrl_if.slave bus,
  output logic [2:0]     dbg_state
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PULSE  = 3'd2,
    HOLD   = 3'd3,
    SAMPLE = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(WE_CYCLES) + 1;
  localparam logic [ADDR_W:0] ROWS_EXT = (ADDR_W + 1)'(ROWS);

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic            write_q, write_nxt;
  logic            err_q, err_nxt;
  logic [ROWS-1:0] sel_q, sel_nxt;
  logic            we_q, we_nxt;
  logic [N-1:0]    din_q, din_nxt;
  logic            rv_q, rv_nxt;
  logic            re_q, re_nxt;
  logic [N-1:0]    rd_q, rd_nxt;
  logic [N-1:0]    rd_mux;
  logic            in_range;

  assign in_range = ({1'b0, bus.req_addr} < ROWS_EXT);

  // The held one-hot select picks the row, so the mux never indexes past the array.
  always_comb begin
    rd_mux = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (sel_q[r]) rd_mux = rd_mux | bus.mem_data_out[r*N +: N];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
      rv_q    <= 1'b0;
      re_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      write_q <= write_nxt;
      err_q   <= err_nxt;
      sel_q   <= sel_nxt;
      we_q    <= we_nxt;
      din_q   <= din_nxt;
      rv_q    <= rv_nxt;
      re_q    <= re_nxt;
      rd_q    <= rd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    write_nxt = write_q;
    err_nxt   = err_q;
    sel_nxt   = sel_q;
    we_nxt    = 1'b0;
    din_nxt   = din_q;
    rv_nxt    = 1'b0;
    re_nxt    = 1'b0;
    rd_nxt    = '0;
    case (state)
      IDLE: begin
        // rst holds the registers cleared, so reaching here implies req_ready.
        if (bus.req_valid) begin
          state_nxt = SETUP;
          write_nxt = bus.req_write;
          err_nxt   = !in_range;
          sel_nxt   = in_range ? (ROWS'(1) << bus.req_addr) : '0;
          if (bus.req_write) din_nxt = bus.req_wdata;
        end
      end
      SETUP: begin
        if (write_q) begin
          state_nxt = PULSE;
          cnt_nxt   = CNT_W'(WE_CYCLES - 1);
          we_nxt    = !err_q;
        end else begin
          state_nxt = SAMPLE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          rv_nxt    = 1'b1;
          re_nxt    = err_q;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          we_nxt  = !err_q;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
      end
      SAMPLE: begin
        state_nxt = RESP;
        sel_nxt   = '0;
        rv_nxt    = 1'b1;
        re_nxt    = err_q;
        rd_nxt    = rd_mux;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  assign bus.req_ready    = (state == IDLE) && !rst;
  assign bus.row_select   = sel_q;
  assign bus.write_enable = we_q;
  assign bus.mem_data_in  = din_q;
  assign bus.rsp_valid    = rv_q;
  assign bus.rsp_err      = re_q;
  assign bus.rsp_rdata    = rd_q;
  assign dbg_state        = state;
endmodule

// File: tb/tb_sram_row_ctrl.sv
// Randomized bench for sram_row_ctrl: per-cycle timing expectations derived from the
// access latencies, a reference memory for responses, and a behavioural row array.
module tb_sram_row_ctrl;
  localparam int N         = 8;
  localparam int ROWS      = 6;
  localparam int ADDR_W    = 3;
  localparam int WE_CYCLES = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;

  sram_row_ctrl_if #(.N(N), .ROWS(ROWS), .ADDR_W(ADDR_W)) bus ();

  sram_row_ctrl #(.N(N), .ROWS(ROWS), .ADDR_W(ADDR_W), .WE_CYCLES(WE_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [N:0]   exp_q[$];
  logic [N-1:0] ref_mem [ROWS];
  logic [N-1:0] init_val [ROWS];
  logic [N-1:0] last_wdata = '0;
  int           exp_rsp = 0;
  int           rsp_count = 0;
  bit           pending_idle = 0;

  // ---------------- behavioural row array ----------------
  logic [N-1:0] mem [ROWS];
  bit           arr_loaded = 0;

  always @(posedge clk) begin
    if (!arr_loaded) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= init_val[r];
      arr_loaded <= 1;
    end else begin
      for (int r = 0; r < ROWS; r++)
        if (bus.write_enable && bus.row_select[r]) mem[r] <= bus.mem_data_in;
    end
  end

  always_comb begin
    bus.mem_data_out = '0;
    for (int r = 0; r < ROWS; r++) bus.mem_data_out[r*N +: N] = mem[r];
  end

  always @(posedge clk) if (bus.rsp_valid) rsp_count <= rsp_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Array-side invariants hold on every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("sel_onehot0", 32'($onehot0(bus.row_select)), 32'd1);
      if (bus.write_enable) check("we_onehot", 32'($onehot(bus.row_select)), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int g);
    bus.req_valid = 1'b0;
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(bus.req_ready), 32'd1);
      check("idle_row", 32'(bus.row_select), 32'd0);
      check("idle_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    if (g > 0) pending_idle = 0;
  endtask

  // Called at a falling edge; drives one request and checks every cycle through its response.
  task automatic do_req(input bit wr, input logic [ADDR_W-1:0] addr, input logic [N-1:0] data,
                        input bit hold);
    bit              in_rng;
    logic [ROWS-1:0] exp_sel;
    logic [N:0]      exp_rsp_word;
    int              lat;
    int              w;
    in_rng  = (int'(addr) < ROWS);
    exp_sel = in_rng ? (ROWS'(1) << addr) : '0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("hs_ready", 32'(bus.req_ready), 32'd1);
    check("ready_lat", 32'(w), pending_idle ? 32'd1 : 32'd0);
    check("pre_row", 32'(bus.row_select), 32'd0);
    check("pre_rdata", 32'(bus.rsp_rdata), 32'd0);
    if (wr) begin
      if (in_rng) ref_mem[addr] = data;
      last_wdata = data;
      exp_q.push_back({!in_rng, N'(0)});
    end else begin
      exp_q.push_back({!in_rng, in_rng ? ref_mem[addr] : N'(0)});
    end
    exp_rsp++;
    lat = wr ? WE_CYCLES + 2 : 3;
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      if (hold) begin
        bus.req_valid = 1'b1;
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
        bus.req_wdata = N'($urandom);
      end else begin
        bus.req_valid = 1'b0;
      end
      check("busy_ready", 32'(bus.req_ready), 32'd0);
      check("row_sel", 32'(bus.row_select), (wr || j < lat) ? 32'(exp_sel) : 32'd0);
      check("write_en", 32'(bus.write_enable),
            32'(wr && in_rng && j >= 2 && j <= WE_CYCLES + 1));
      check("mem_din", 32'(bus.mem_data_in), 32'(last_wdata));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(j == lat));
      if (j == lat) begin
        exp_rsp_word = exp_q.pop_front();
        check("rsp_word", 32'({bus.rsp_err, bus.rsp_rdata}), 32'(exp_rsp_word));
      end else begin
        check("rdata_zero", 32'({bus.rsp_err, bus.rsp_rdata}), 32'd0);
      end
    end
    pending_idle = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int r = 0; r < ROWS; r++) begin
      init_val[r] = N'($urandom);
      ref_mem[r]  = init_val[r];
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_row", 32'(bus.row_select), 32'd0);
    check("rst_we", 32'(bus.write_enable), 32'd0);
    check("rst_din", 32'(bus.mem_data_in), 32'd0);
    check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 32'd0);
    rst = 1'b0;
    idle_cycles(1);

    // Directed: write then read row 3.
    do_req(1'b1, 3'd3, 8'hA5, 1'b0);
    do_req(1'b0, 3'd3, 8'h00, 1'b0);
    idle_cycles(2);

    // Back-to-back with req_valid held: rows 0..7 (6 and 7 are out of range).
    for (int i = 0; i < 8; i++) do_req(1'b1, ADDR_W'(i), N'((i + 1) * 8'h11), 1'b1);
    for (int i = 0; i < 8; i++) do_req(1'b0, ADDR_W'(i), 8'h00, 1'b1);

    // Out-of-range write/read, then full-scale data at row 0.
    do_req(1'b1, 3'd7, 8'h3C, 1'b0);
    do_req(1'b0, 3'd7, 8'h00, 1'b0);
    do_req(1'b1, 3'd0, 8'hFF, 1'b0);
    do_req(1'b0, 3'd0, 8'h00, 1'b1);

    // Randomized mix with random gaps.
    for (int t = 0; t < 60; t++) begin
      bit hold;
      hold = 1'($urandom_range(0, 1));
      do_req(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)),
             N'($urandom), hold);
      if (!hold) idle_cycles($urandom_range(0, 2));
    end

    // Reset asserted mid-pulse abandons the write without a response.
    idle_cycles(1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 3'd2;
    bus.req_wdata = ~ref_mem[2];
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_we_on", 32'(bus.write_enable), 32'd1);
    check("abort_row_on", 32'(bus.row_select), 32'(ROWS'(1) << 2));
    #2 rst = 1'b1;
    #1;
    check("abort_row", 32'(bus.row_select), 32'd0);
    check("abort_we", 32'(bus.write_enable), 32'd0);
    check("abort_din", 32'(bus.mem_data_in), 32'd0);
    check("abort_ready", 32'(bus.req_ready), 32'd0);
    last_wdata = '0;
    repeat (2) @(negedge clk);
    check("abort_rsp", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    pending_idle = 0;
    @(negedge clk);
    do_req(1'b0, 3'd2, 8'h00, 1'b0);
    idle_cycles(3);

    check("rsp_count", 32'(rsp_count), 32'(exp_rsp));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    for (int r = 0; r < ROWS; r++) check("array_row", 32'(mem[r]), 32'(ref_mem[r]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
